// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART buffering blocks.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // Width needed to hold an occupancy in the range 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with optional first-word-fall-through, threshold flags,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_ext
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH      = UART_DATA_W,
  parameter int unsigned DEPTH      = UART_FIFO_DEPTH,
  parameter int unsigned AFULL_LVL  = DEPTH - 2,
  parameter int unsigned AEMPTY_LVL = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic [WIDTH-1:0] rdata;
  logic             rd_acc, wr_acc;

  // Flags come only from registered occupancy.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CntW'(DEPTH));
  assign almost_full  = (AFULL_LVL != 0) && (count_q >= CntW'(AFULL_LVL));
  assign almost_empty = (count_q <= CntW'(AEMPTY_LVL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  fifo_mem #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Next-state for pointers, occupancy, sticky flags and the read register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    if (flush) begin
      // data_out deliberately keeps its last value across a flush.
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        dout_d   = rdata;
        dvalid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en && !wr_acc) overflow_d  = 1'b1;
      if (rd_en && empty)   underflow_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
    end
  end

  // FWFT shows the head directly; when empty it holds the last popped word.
  assign data_out   = (FWFT != 0) ? (empty ? dout_q : rdata) : dout_q;
  assign data_valid = (FWFT != 0) ? !empty : dvalid_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench: a standard-read and an FWFT instance share stimulus.
module tb_sync_fifo_ext;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 14;
  localparam int unsigned AE = 2;
  localparam int unsigned CW = uart_pkg::cnt_width(D);

  logic          clk, rst_n, flush, wr_en, rd_en;
  logic [W-1:0]  data_in;

  logic [W-1:0]  d0_data_out, d1_data_out;
  logic          d0_data_valid, d1_data_valid;
  logic          d0_empty, d0_full, d0_ae, d0_af, d0_ovf, d0_unf;
  logic          d1_empty, d1_full, d1_ae, d1_af, d1_ovf, d1_unf;
  logic [CW-1:0] d0_count, d1_count;

  int            n_tests = 0;
  int            n_fail  = 0;

  logic [W-1:0]  exp_q [$];
  int            m_cnt;
  logic          m_ovf, m_unf, m_valid;
  logic [W-1:0]  last_word;

  sync_fifo_ext #(
    .WIDTH (W), .DEPTH (D), .AFULL_LVL (AF), .AEMPTY_LVL (AE), .FWFT (0)
  ) u_dut_std (
    .clk (clk), .rst_n (rst_n), .flush (flush), .wr_en (wr_en), .data_in (data_in),
    .rd_en (rd_en), .data_out (d0_data_out), .data_valid (d0_data_valid),
    .empty (d0_empty), .full (d0_full), .almost_empty (d0_ae), .almost_full (d0_af),
    .count (d0_count), .overflow (d0_ovf), .underflow (d0_unf)
  );

  sync_fifo_ext #(
    .WIDTH (W), .DEPTH (D), .AFULL_LVL (AF), .AEMPTY_LVL (AE), .FWFT (1)
  ) u_dut_fwft (
    .clk (clk), .rst_n (rst_n), .flush (flush), .wr_en (wr_en), .data_in (data_in),
    .rd_en (rd_en), .data_out (d1_data_out), .data_valid (d1_data_valid),
    .empty (d1_empty), .full (d1_full), .almost_empty (d1_ae), .almost_full (d1_af),
    .count (d1_count), .overflow (d1_ovf), .underflow (d1_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt     = 0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    m_valid   = 1'b0;
    last_word = '0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_dout"},   32'(d0_data_out), 0);
    check_eq({tag, "_valid"},  32'(d0_data_valid), 0);
    check_eq({tag, "_count"},  32'(d0_count), 0);
    check_eq({tag, "_empty"},  32'(d0_empty), 1);
    check_eq({tag, "_full"},   32'(d0_full), 0);
    check_eq({tag, "_aempty"}, 32'(d0_ae), 1);
    check_eq({tag, "_afull"},  32'(d0_af), 0);
    check_eq({tag, "_ovf"},    32'(d0_ovf), 0);
    check_eq({tag, "_unf"},    32'(d0_unf), 0);
    check_eq({tag, "_fwft_dout"},  32'(d1_data_out), 0);
    check_eq({tag, "_fwft_valid"}, 32'(d1_data_valid), 0);
  endtask

  task automatic check_status();
    check_eq("count",  32'(d0_count), 32'(m_cnt));
    check_eq("empty",  32'(d0_empty), 32'(m_cnt == 0));
    check_eq("full",   32'(d0_full),  32'(m_cnt == D));
    check_eq("aempty", 32'(d0_ae),    32'(m_cnt <= AE));
    check_eq("afull",  32'(d0_af),    32'(m_cnt >= AF));
    check_eq("ovf",    32'(d0_ovf),   32'(m_ovf));
    check_eq("unf",    32'(d0_unf),   32'(m_unf));
    check_eq("valid",  32'(d0_data_valid), 32'(m_valid));
    check_eq("fwft_count", 32'(d1_count), 32'(m_cnt));
    check_eq("fwft_valid", 32'(d1_data_valid), 32'(m_cnt != 0));
  endtask

  // One clock of stimulus; model updated alongside, outputs checked #1 after the edge.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic f);
    logic rd_acc, wr_acc;
    logic [W-1:0] word;
    wr_en = w; data_in = d; rd_en = r; flush = f;
    if (f) begin
      exp_q.delete();
      m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
    end else begin
      rd_acc = r && (m_cnt != 0);
      wr_acc = w && ((m_cnt != D) || rd_acc);
      if (w && !wr_acc) m_ovf = 1'b1;
      if (r && (m_cnt == 0)) m_unf = 1'b1;
      if (wr_acc) exp_q.push_back(d);
      m_valid = rd_acc;
      if (wr_acc && !rd_acc) m_cnt++;
      else if (rd_acc && !wr_acc) m_cnt--;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    check_status();
    if (m_valid) begin
      word      = exp_q.pop_front();
      last_word = word;
      check_eq("dout", 32'(d0_data_out), 32'(word));
    end
    if (m_cnt != 0) check_eq("fwft_head", 32'(d1_data_out), 32'(exp_q[0]));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    model_reset();
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic ordering and 1-cycle read latency.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill, overflow, then full with simultaneous read/write; drain fully.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush keeps data_out; then write+read on empty.
    cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("flush_dout_hold", 32'(d0_data_out), 32'(last_word));
    cycle(1'b1, 8'h5C, 1'b1, 1'b0);
    check_eq("fwft_5c", 32'(d1_data_out), 32'h5C);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush at count 9 with overflow set; same-cycle write is ignored.
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("pre_flush_count", 32'(d0_count), 9);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    check_eq("flush_dout_hold2", 32'(d0_data_out), 32'(last_word));
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
    wr_en = 1'b1; data_in = 8'h34;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("midreset");
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h12, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised synchronous FIFO; next generation of the UART buffering FIFO. Adds a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, a synchronous flush, a read-data-valid strobe, and sticky overflow/underflow error flags. Sits between the UART RX/TX engines and the host/register interface; one instance per direction.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `DEPTH`, 16, storage entries (≥2; need not be a power of two).
- `AFULL_LVL`, DEPTH-2, `almost_full` asserts when count ≥ this value (1..DEPTH).
- `AEMPTY_LVL`, 2, `almost_empty` asserts when count ≤ this value (0..DEPTH-1).
- `FWFT`, 0, 0 = standard registered read; 1 = first-word-fall-through.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of contents and error flags.
- `wr_en`  in  1  write request.
- `data_in`  in  WIDTH  write data.
- `rd_en`  in  1  read request (FWFT: acknowledge of head word).
- `data_out`  out  WIDTH  read data.
- `data_valid`  out  1  `data_out` holds a valid word (see Operation).
- `empty`, `full`  out  1  count == 0 / count == DEPTH.
- `almost_empty`, `almost_full`  out  1  threshold flags.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Read accepted (`rd_acc`) = `rd_en` && !`empty`. Write accepted (`wr_acc`) = `wr_en` && (!`full` || `rd_acc`).
- Write and read pointers advance 0..DEPTH-1 and wrap to 0 explicitly (no reliance on power-of-two overflow).
- Count: +1 on `wr_acc` only; −1 on `rd_acc` only; unchanged when both are accepted or neither is.
- Full with `rd_en` and `wr_en`: both accepted; count stays DEPTH.
- Empty with `rd_en` and `wr_en`: write only; `underflow` set; count becomes 1.
- `overflow` sets on `wr_en` && !`wr_acc`. `underflow` sets on `rd_en` && `empty`. Both stay set until `flush` or reset.
- `flush` has priority over same-cycle `wr_en`/`rd_en`, which are ignored. It zeroes pointers, count and error flags; it leaves `data_out` unchanged and clears `data_valid`.
- Standard mode (FWFT=0): on `rd_acc`, `data_out` loads the head word at the next edge and `data_valid` pulses high for exactly that cycle. Otherwise `data_out` holds its value and `data_valid` = 0.
- FWFT mode (FWFT=1): `data_out` = head entry whenever !`empty`; `data_valid` = !`empty`; `rd_en` pops the head.
- Flags and `count` are registered or derived only from registered state; no combinational path from `wr_en`/`rd_en` to any flag.

## Timing
- Reset (async assert, sync deassert handled upstream): `data_out`=0, `data_valid`=0, `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=(AFULL_LVL==0 → never; i.e. 0), `overflow`=0, `underflow`=0, pointers=0.
- Reset mid-transfer: contents discarded; first write after `rst_n` rises lands in entry 0.
- Write to flag update: 1 cycle (`empty` falls at the edge after the write).
- Standard read latency: 1 cycle from the `rd_en` edge to `data_out`/`data_valid`.
- FWFT write-to-visible latency: 1 cycle (word appears on `data_out` the cycle `empty` falls).
- Back-to-back reads and writes sustain one word per cycle each.

## Structure
- Shared package `uart_pkg`: default `UART_DATA_W`=8 and `UART_FIFO_DEPTH`=16 constants; the count-width expression $clog2(DEPTH+1) is a package function/macro used by all FIFO users.
- Sub-module `fifo_mem`: DEPTH×WIDTH register array with synchronous write port and asynchronous read port. The top level holds pointers, count, flags and the output register/FWFT mux.

## Test plan
- Reset, write 0xA1..0xA4 (FWFT=0), then 4 reads → `data_out` 0xA1..0xA4, each 1 cycle after its `rd_en` with a `data_valid` pulse; `empty`=1 after the last read; count sequence 4,3,2,1,0.
- Fill DEPTH=16, then an extra write → `full`=1, `overflow`=1 sticky, count=16; the 17th word is absent on readback.
- Full plus simultaneous `rd_en`/`wr_en` for 5 cycles → count stays 16, ordering preserved; pointer wrap past entry 15 verified.
- Empty plus `rd_en`&`wr_en` 0x5C → `underflow`=1, count=1; FWFT=1 build shows 0x5C on `data_out` with `data_valid`=1 the next cycle.
- Thresholds AFULL_LVL=14, AEMPTY_LVL=2: ramp count 0→16→0 → `almost_empty` high for counts 0..2, `almost_full` high for 14..16.
- At count 9 with `overflow` set, assert `flush` with `wr_en` → count=0, `empty`=1, `overflow`=0, write ignored. Separately, drop `rst_n` mid-burst → all outputs at reset values the same cycle.
